// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the gate-logic checker: widths, FSM states,
// LFSR parameters and the delay-line entry layout.
package gate_chk_pkg;

  localparam int unsigned PAT_W  = 14;
  localparam int unsigned RESP_W = 12;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  localparam logic [PAT_W-1:0] LFSR_SEED = 14'h0001;
  // Feedback taps: pat[13], pat[12], pat[11], pat[1]
  localparam logic [PAT_W-1:0] LFSR_TAPS = 14'h3802;
  localparam logic [PAT_W-1:0] PAT_LAST  = 14'h3FFF;

  typedef struct packed {
    logic              valid;
    logic [PAT_W-1:0]  pat;
    logic [RESP_W-1:0] e;
  } dl_entry_t;

  function automatic logic [PAT_W-1:0] lfsr_next(input logic [PAT_W-1:0] p);
    return {p[PAT_W-2:0], ^(p & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/gate_chk_model.sv
// Golden combinational model of the gate logic under test: pattern in, expected
// 12-bit response out.
module gate_chk_model
  import gate_chk_pkg::*;
(
  input  logic [PAT_W-1:0]  pat,
  output logic [RESP_W-1:0] e
);

  logic [7:0] u;
  logic [5:0] v;

  always_comb begin
    u     = pat[7:0];
    v     = pat[13:8];
    e     = '0;
    e[0]  = u[0] ^ u[1];
    e[1]  = u[2] & u[3];
    e[2]  = u[4] | u[5];
    e[3]  = ~u[6];
    e[4]  = u[7];
    e[5]  = v[0] ^ v[1];
    e[6]  = v[2] & v[3];
    e[7]  = v[4] | v[5];
    e[8]  = u[0] & u[1];
    e[9]  = u[2] | u[3];
    e[10] = u[4] ^ u[7];
    e[11] = ~(u[5] & u[6]);
  end

endmodule

// File: rtl/gate_logic_checker.sv
// Drives exhaustive or LFSR patterns into external gate logic, compares the
// LAT-delayed responses against the golden model and accumulates mismatches.
module gate_logic_checker
  import gate_chk_pkg::*;
#(
  parameter int unsigned LAT   = 1,
  parameter int unsigned ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  output logic [7:0]       stim_ui,
  output logic [5:0]       stim_uio,
  input  logic [7:0]       resp_uo,
  input  logic [3:0]       resp_uio,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [PAT_W-1:0] first_err_pat
);

  localparam logic [2:0] DrainLast = 3'(LAT == 0 ? 0 : LAT - 1);

  state_e             state_q;
  logic               mode_q;
  logic [PAT_W-1:0]   pat_q;
  logic [2:0]         drain_cnt_q;
  logic [ERR_W-1:0]   err_cnt_q;
  logic [PAT_W-1:0]   first_err_q;

  logic [RESP_W-1:0]  exp_e;
  logic [RESP_W-1:0]  obs;
  logic               last;
  logic               mismatch;
  dl_entry_t          dl_in;
  dl_entry_t          cmp;

  gate_chk_model u_model (
    .pat (pat_q),
    .e   (exp_e)
  );

  always_comb begin
    dl_in       = '0;
    dl_in.valid = (state_q == StRun);
    dl_in.pat   = pat_q;
    dl_in.e     = exp_e;
  end

  // Entries only carry valid=1 while running, so the line is empty again by DONE
  if (LAT == 0) begin : g_no_dl
    assign cmp = dl_in;
  end else begin : g_dl
    dl_entry_t dl_q [LAT];
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int unsigned i = 0; i < LAT; i++) dl_q[i] <= '0;
      end else begin
        dl_q[0] <= dl_in;
        for (int unsigned i = 1; i < LAT; i++) dl_q[i] <= dl_q[i-1];
      end
    end
    assign cmp = dl_q[LAT-1];
  end

  assign obs      = {resp_uio, resp_uo};
  assign mismatch = cmp.valid && (obs != cmp.e);
  assign last     = mode_q ? (lfsr_next(pat_q) == LFSR_SEED) : (pat_q == PAT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      mode_q      <= 1'b0;
      pat_q       <= '0;
      drain_cnt_q <= '0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
    end else begin
      if (mismatch) begin
        if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + ERR_W'(1);
        if (err_cnt_q == '0) first_err_q <= cmp.pat;
      end
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q     <= StRun;
            mode_q      <= mode;
            pat_q       <= mode ? LFSR_SEED : '0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
          end
        end
        StRun: begin
          if (last) begin
            pat_q       <= '0;
            drain_cnt_q <= '0;
            state_q     <= (LAT == 0) ? StDone : StDrain;
          end else begin
            pat_q <= mode_q ? lfsr_next(pat_q) : pat_q + 14'd1;
          end
        end
        StDrain: begin
          if (drain_cnt_q == DrainLast) state_q <= StDone;
          else drain_cnt_q <= drain_cnt_q + 3'd1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy          = (state_q == StRun) || (state_q == StDrain);
  assign done          = (state_q == StDone);
  assign pass          = done && (err_cnt_q == '0);
  assign err_cnt       = err_cnt_q;
  assign first_err_pat = first_err_q;
  assign stim_ui       = (state_q == StRun) ? pat_q[7:0]  : 8'h00;
  assign stim_uio      = (state_q == StRun) ? pat_q[13:8] : 6'h00;

endmodule

// File: tb/tb_gate_logic_checker.sv
// Bench for gate_logic_checker: four instances (LAT 1/2/0, ERR_W 16/8) looped
// back through a delayed, optionally faulted copy of the gate logic.
module tb_gate_logic_checker;

  localparam int NI = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start_a [NI];
  logic        mode_a  [NI];
  logic        busy_a  [NI];
  logic        done_a  [NI];
  logic        pass_a  [NI];
  logic [7:0]  ui_a    [NI];
  logic [5:0]  uio_a   [NI];
  logic [7:0]  ruo_a   [NI];
  logic [3:0]  ruio_a  [NI];
  logic [15:0] err_a   [NI];
  logic [13:0] fep_a   [NI];
  int          flt     [NI];

  int total = 0;
  int bad   = 0;

  function automatic logic [11:0] gold(input logic [13:0] p);
    logic [7:0]  u;
    logic [5:0]  v;
    logic [11:0] e;
    u = p[7:0];
    v = p[13:8];
    e = {!(u[5] & u[6]), u[4] ^ u[7], u[2] | u[3], u[0] & u[1],
         v[4] | v[5], v[2] & v[3], v[0] ^ v[1], u[7],
         !u[6], u[4] | u[5], u[2] & u[3], u[0] ^ u[1]};
    return e;
  endfunction

  // 0: clean, 1: uo[3] stuck at 0, 2: all bits inverted, 3: bit 0 flipped at pattern 5
  function automatic logic [11:0] faulty(input logic [11:0] g, input logic [13:0] p, input int f);
    case (f)
      1:       return g & ~12'h008;
      2:       return ~g;
      3:       return (p == 14'h0005) ? (g ^ 12'h001) : g;
      default: return g;
    endcase
  endfunction

  function automatic logic [13:0] tb_lfsr(input logic [13:0] p);
    return {p[12:0], p[13] ^ p[12] ^ p[11] ^ p[1]};
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned L = (g == 1) ? 2 : (g == 2) ? 0 : 1;
    localparam int unsigned W = (g == 3) ? 8 : 16;
    logic [W-1:0] err_w;
    logic [11:0]  word;
    logic [11:0]  hist [4];

    gate_logic_checker #(.LAT(L), .ERR_W(W)) u_dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start_a[g]),
      .mode          (mode_a[g]),
      .stim_ui       (ui_a[g]),
      .stim_uio      (uio_a[g]),
      .resp_uo       (ruo_a[g]),
      .resp_uio      (ruio_a[g]),
      .busy          (busy_a[g]),
      .done          (done_a[g]),
      .pass          (pass_a[g]),
      .err_cnt       (err_w),
      .first_err_pat (fep_a[g])
    );
    assign err_a[g] = 16'(err_w);

    always_comb word = faulty(gold({uio_a[g], ui_a[g]}), {uio_a[g], ui_a[g]}, flt[g]);
    always @(posedge clk) begin
      hist[0] <= word;
      for (int k = 1; k < 4; k++) hist[k] <= hist[k-1];
    end
    if (L == 0) begin : g_comb
      assign ruo_a[g]  = word[7:0];
      assign ruio_a[g] = word[11:8];
    end else begin : g_dly
      assign ruo_a[g]  = hist[L-1][7:0];
      assign ruio_a[g] = hist[L-1][11:8];
    end
  end

  // Starts a run, checks every stimulus cycle against a queued model pattern and
  // folds the expected mismatches into the expected error count / first pattern.
  task automatic run_scored(input int i, input bit m, input int errw, output int cyc,
                            output int exp_err, output logic [13:0] exp_first,
                            output int stim_bad, output logic [13:0] first_stim);
    logic [13:0] q[$];
    logic [13:0] mp, got, want;
    logic [11:0] g;
    int idx, npat, sat;
    npat = m ? 16383 : 16384;
    sat = (1 << errw) - 1;
    exp_err = 0; exp_first = '0; stim_bad = 0; first_stim = '0; idx = 0;
    mp = m ? 14'h0001 : 14'h0000;
    @(negedge clk);
    mode_a[i] = m;
    start_a[i] = 1'b1;
    @(posedge clk);
    cyc = 1;
    #1 start_a[i] = 1'b0;
    forever begin
      @(negedge clk);
      if (done_a[i] === 1'b1) break;
      if (cyc > 20000) begin
        total++; bad++;
        $display("FAIL run_timeout[%0d]: got no done after %0d cycles want done", i, cyc);
        break;
      end
      got = {uio_a[i], ui_a[i]};
      if (idx < npat) begin
        q.push_back(mp);
        if (idx == 0) first_stim = got;
        g = gold(mp);
        if (faulty(g, mp, flt[i]) != g) begin
          if (exp_err == 0) exp_first = mp;
          if (exp_err < sat) exp_err++;
        end
        mp = m ? tb_lfsr(mp) : mp + 14'd1;
        idx++;
      end else begin
        q.push_back(14'h0000);
      end
      want = q.pop_front();
      if (got !== want) stim_bad++;
      @(posedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    #12;
    for (int i = 0; i < NI; i++) begin
      total++;
      if ({busy_a[i], done_a[i], pass_a[i], err_a[i], fep_a[i], uio_a[i], ui_a[i]} !== '0) begin
        bad++;
        $display("FAIL reset_state[%0d]: got busy=%b done=%b pass=%b err=%0h fep=%0h stim=%0h want all 0",
                 i, busy_a[i], done_a[i], pass_a[i], err_a[i], fep_a[i], {uio_a[i], ui_a[i]});
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_loopback();
    int cyc, ee, sb;
    logic [13:0] ef, fs;
    flt[0] = 0;
    run_scored(0, 1'b0, 16, cyc, ee, ef, sb, fs);
    total++; if (cyc !== 16386) begin bad++; $display("FAIL loop_latency: got %0d want 16386", cyc); end
    total++; if (sb !== 0) begin bad++; $display("FAIL loop_stim: got %0d bad cycles want 0", sb); end
    total++; if (err_a[0] !== 16'(ee)) begin bad++; $display("FAIL loop_err: got %0d want %0d", err_a[0], ee); end
    total++; if (fep_a[0] !== ef) begin bad++; $display("FAIL loop_fep: got %0h want %0h", fep_a[0], ef); end
    total++; if ({pass_a[0], busy_a[0]} !== 2'b10) begin
      bad++; $display("FAIL loop_pass_busy: got %b%b want 10", pass_a[0], busy_a[0]);
    end
    repeat (3) @(negedge clk);
    total++; if (done_a[0] !== 1'b1) begin bad++; $display("FAIL loop_done_held: got %b want 1", done_a[0]); end
  endtask

  task automatic test_lfsr();
    int cyc, ee, sb;
    logic [13:0] ef, fs;
    flt[1] = 0;
    run_scored(1, 1'b1, 16, cyc, ee, ef, sb, fs);
    total++; if (fs !== 14'h0001) begin bad++; $display("FAIL lfsr_first_stim: got %0h want 1", fs); end
    total++; if (sb !== 0) begin bad++; $display("FAIL lfsr_stim: got %0d bad cycles want 0", sb); end
    total++; if (cyc !== 16386) begin bad++; $display("FAIL lfsr_latency: got %0d want 16386", cyc); end
    total++; if (err_a[1] !== 16'(ee)) begin bad++; $display("FAIL lfsr_err: got %0d want %0d", err_a[1], ee); end
    total++; if (pass_a[1] !== 1'b1) begin bad++; $display("FAIL lfsr_pass: got %b want 1", pass_a[1]); end
  endtask

  task automatic test_saturate();
    int cyc, ee, sb;
    logic [13:0] ef, fs;
    flt[3] = 2;
    run_scored(3, 1'b0, 8, cyc, ee, ef, sb, fs);
    total++; if (err_a[3] !== 16'(ee)) begin bad++; $display("FAIL sat_err: got %0h want %0h", err_a[3], ee); end
    total++; if (fep_a[3] !== ef) begin bad++; $display("FAIL sat_fep: got %0h want %0h", fep_a[3], ef); end
    total++; if (pass_a[3] !== 1'b0) begin bad++; $display("FAIL sat_pass: got %b want 0", pass_a[3]); end
    total++; if (sb !== 0) begin bad++; $display("FAIL sat_stim: got %0d bad cycles want 0", sb); end
  endtask

  task automatic test_single_flip();
    int cyc, ee, sb;
    logic [13:0] ef, fs;
    flt[2] = 3;
    run_scored(2, 1'b0, 16, cyc, ee, ef, sb, fs);
    total++; if (err_a[2] !== 16'(ee)) begin bad++; $display("FAIL flip_err: got %0d want %0d", err_a[2], ee); end
    total++; if (fep_a[2] !== ef) begin bad++; $display("FAIL flip_fep: got %0h want %0h", fep_a[2], ef); end
    total++; if (cyc !== 16385) begin bad++; $display("FAIL flip_latency: got %0d want 16385", cyc); end
    total++; if (pass_a[2] !== 1'b0) begin bad++; $display("FAIL flip_pass: got %b want 0", pass_a[2]); end
  endtask

  // Mid-run start is ignored, async reset aborts, then a fresh run with a stuck bit
  task automatic test_abort_restart();
    int cyc, ee, sb, n;
    logic [13:0] ef, fs;
    flt[0] = 1;
    @(negedge clk);
    mode_a[0] = 1'b0; start_a[0] = 1'b1;
    @(posedge clk);
    #1 start_a[0] = 1'b0;
    n = 0;
    while ({uio_a[0], ui_a[0]} !== 14'd50 && n < 200) begin @(negedge clk); n++; end
    mode_a[0] = 1'b1; start_a[0] = 1'b1;
    @(posedge clk);
    #1 start_a[0] = 1'b0;
    @(negedge clk);
    total++; if ({busy_a[0], uio_a[0], ui_a[0]} !== {1'b1, 14'd51}) begin
      bad++; $display("FAIL ignore_start: got busy=%b stim=%0d want busy=1 stim=51",
                      busy_a[0], {uio_a[0], ui_a[0]});
    end
    n = 0;
    while ({uio_a[0], ui_a[0]} !== 14'd100 && n < 200) begin @(negedge clk); n++; end
    total++; if (err_a[0] === 16'd0) begin bad++; $display("FAIL abort_err_before: got 0 want nonzero"); end
    rst = 1'b1;
    #1;
    total++; if ({busy_a[0], done_a[0], pass_a[0], err_a[0], fep_a[0], uio_a[0], ui_a[0]} !== '0) begin
      bad++; $display("FAIL abort_reset: got busy=%b done=%b pass=%b err=%0h fep=%0h stim=%0h want all 0",
                      busy_a[0], done_a[0], pass_a[0], err_a[0], fep_a[0], {uio_a[0], ui_a[0]});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    total++; if ({busy_a[0], done_a[0]} !== 2'b00) begin
      bad++; $display("FAIL abort_no_done: got busy=%b done=%b want 00", busy_a[0], done_a[0]);
    end
    run_scored(0, 1'b0, 16, cyc, ee, ef, sb, fs);
    total++; if (err_a[0] !== 16'(ee)) begin bad++; $display("FAIL stuck_err: got %0d want %0d", err_a[0], ee); end
    total++; if (fep_a[0] !== ef) begin bad++; $display("FAIL stuck_fep: got %0h want %0h", fep_a[0], ef); end
    total++; if (pass_a[0] !== 1'b0) begin bad++; $display("FAIL stuck_pass: got %b want 0", pass_a[0]); end
    total++; if (cyc !== 16386) begin bad++; $display("FAIL stuck_latency: got %0d want 16386", cyc); end
    total++; if (sb !== 0) begin bad++; $display("FAIL stuck_stim: got %0d bad cycles want 0", sb); end
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      start_a[i] = 1'b0;
      mode_a[i]  = 1'b0;
      flt[i]     = 0;
    end
    test_reset();
    fork
      test_loopback();
      test_lfsr();
      test_saturate();
      test_single_flip();
    join
    test_abort_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
